// File: rtl/rr_arb_client.sv
// rr_arb_client: requester front end for a 4-way round-robin arbiter; queues burst requests per channel.
// Optional GNT protocol checker enabled by defining RR_ARB_CLIENT_GNT_CHECK_EN.
module rr_arb_client #(
  parameter int N         = 4,
  parameter int BURST_LEN = 2,
  parameter int PEND_W    = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] push,
  input  logic [N-1:0] GNT,
  output logic [N-1:0] REQ,
  output logic [N-1:0] beat,
  output logic [N-1:0] done,
  output logic [N-1:0] pend_full,
  output logic         err
);
  typedef enum logic [1:0] {IDLE, ACTIVE, RELEASE} state_t;
  localparam logic [PEND_W-1:0] PMAX = '1;
  localparam logic [PEND_W-1:0] ONE  = PEND_W'(1);
  localparam logic [7:0]        LAST = 8'(BURST_LEN - 1);
  assign beat = REQ & GNT;
  for (genvar i = 0; i < N; i++) begin : g_ch
    state_t            state;
    logic [PEND_W-1:0] pend;
    logic [7:0]        bcnt;
    logic              req_q, done_q, last;
    assign last         = beat[i] && bcnt == LAST;
    assign pend_full[i] = pend == PMAX;
    assign REQ[i]       = req_q;
    assign done[i]      = done_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        state  <= IDLE;
        pend   <= '0;
        bcnt   <= '0;
        req_q  <= 1'b0;
        done_q <= 1'b0;
      end else begin
        done_q <= 1'b0;
        // a push coinciding with completion is always accepted, even at max
        if (push[i] && !last && !pend_full[i]) pend <= pend + ONE;
        else if (!push[i] && last) pend <= pend - ONE;
        case (state)
          IDLE: if (pend != '0 || push[i]) begin
            state <= ACTIVE;
            req_q <= 1'b1;
          end
          ACTIVE: if (beat[i]) begin
            if (last) begin
              bcnt   <= '0;
              state  <= RELEASE;
              req_q  <= 1'b0;
              done_q <= 1'b1;
            end else bcnt <= bcnt + 8'd1;
          end
          RELEASE: begin
            state <= (pend != '0 || push[i]) ? ACTIVE : IDLE;
            req_q <= pend != '0 || push[i];
          end
          default: begin
            state <= IDLE;
            req_q <= 1'b0;
          end
        endcase
      end
    end
  end
`ifdef RR_ARB_CLIENT_GNT_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else if ((GNT & (GNT - 1'b1)) != '0 || (GNT & ~REQ) != '0) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_rr_arb_client.sv
// tb_rr_arb_client: directed self-checking bench for rr_arb_client (N=4, BURST_LEN=2, PEND_W=2).
module tb_rr_arb_client;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] push, GNT, REQ, beat, done, pend_full;
  logic       err;
  int checks = 0;
  int failures = 0;
`ifdef RR_ARB_CLIENT_GNT_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  rr_arb_client dut (.clk(clk), .rst(rst), .push(push), .GNT(GNT), .REQ(REQ),
                     .beat(beat), .done(done), .pend_full(pend_full), .err(err));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] gnt_m;
    int ptr, k, dcnt;
    bit found;
    rst = 1'b1; push = 4'b1111; GNT = 4'b0000;
    tick(); tick();
    rst = 1'b0; push = 4'b0000;
    chk("rst_req", REQ, 4'b0000);
    chk("rst_done", done, 4'b0000);
    chk("rst_err", err, 1'b0);
    chk("rst_full", pend_full, 4'b0000);
    tick();
    chk("rst_no_req", REQ, 4'b0000);

    // single burst on channel 1
    push = 4'b0010; tick(); push = 4'b0000;
    chk("sb_req", REQ, 4'b0010);
    GNT = 4'b0010; #1;
    chk("sb_beat0", beat, 4'b0010);
    tick();
    chk("sb_req2", REQ, 4'b0010);
    chk("sb_beat1", beat, 4'b0010);
    tick(); GNT = 4'b0000;
    chk("sb_rel_req", REQ, 4'b0000);
    chk("sb_done", done, 4'b0010);
    chk("sb_rel_beat", beat, 4'b0000);
    tick();
    chk("sb_idle_req", REQ, 4'b0000);
    chk("sb_idle_done", done, 4'b0000);

    // saturation on channel 0
    push = 4'b0001; tick(); tick();
    chk("sat_full2", pend_full, 4'b0000);
    tick();
    chk("sat_full3", pend_full, 4'b0001);
    tick(); tick(); push = 4'b0000;
    chk("sat_full5", pend_full, 4'b0001);
    chk("sat_req", REQ, 4'b0001);
    dcnt = 0;
    for (int c = 0; c < 12; c++) begin
      GNT = REQ & 4'b0001;
      tick();
      if (done[0]) dcnt++;
    end
    GNT = 4'b0000;
    chk("sat_dones", dcnt, 3);
    chk("sat_idle_req", REQ, 4'b0000);
    chk("sat_empty", pend_full, 4'b0000);

    // grant loss mid-burst on channel 2
    push = 4'b0100; tick(); push = 4'b0000;
    GNT = 4'b0100; tick(); GNT = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      chk("gl_req_hold", REQ, 4'b0100);
      chk("gl_no_done", done, 4'b0000);
      tick();
    end
    chk("gl_req_hold3", REQ, 4'b0100);
    GNT = 4'b0100; tick(); GNT = 4'b0000;
    chk("gl_done", done, 4'b0100);
    chk("gl_rel_req", REQ, 4'b0000);
    tick();
    chk("gl_idle_req", REQ, 4'b0000);

    // rotation against a behavioural round-robin arbiter
    push = 4'b1111; tick(); push = 4'b0000;
    chk("rot_req", REQ, 4'b1111);
    gnt_m = 4'b0000; ptr = 3; k = 0;
    for (int c = 0; c < 40; c++) begin
      if (done != 4'b0000) begin
        chk("rot_order", done, k < 4 ? 4'b0001 << k : 4'b0000);
        chk("rot_release", REQ & done, 4'b0000);
        k++;
      end
      if ((gnt_m & REQ) == 4'b0000) begin
        gnt_m = 4'b0000; found = 1'b0;
        for (int j = 1; j <= 4; j++) begin
          int ch;
          ch = (ptr + j) % 4;
          if (!found && REQ[ch]) begin
            gnt_m = 4'b0001 << ch; ptr = ch; found = 1'b1;
          end
        end
      end
      GNT = gnt_m;
      tick();
    end
    GNT = 4'b0000;
    chk("rot_count", k, 4);
    chk("rot_idle", REQ, 4'b0000);

    // protocol checker
    rst = 1'b1; tick(); rst = 1'b0;
    chk("chk_rst", err, 1'b0);
    GNT = 4'b0011; tick(); GNT = 4'b0000;
    chk("chk_multi", err, EXP_ERR);
    tick(); tick();
    chk("chk_sticky", err, EXP_ERR);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("chk_clear", err, 1'b0);
    GNT = 4'b1000; tick(); GNT = 4'b0000;
    chk("chk_noreq", err, EXP_ERR);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
